// File: rtl/sdram_port_arbiter_if.sv
// Bundle of requester-side and controller-side signals around sdram_port_arbiter.
// Parameter HADDR_WIDTH must match the arbiter instance it is bound to.
//
// Handshake rules:
//   Requesters raise dsp_req/host_req as a level and keep address/data stable.
//   They drop the request only after the matching one-cycle dsp_ack/host_ack.
//   The arbiter raises one controller strobe (sd_rd_enable, sd_wr_enable or sd_rd_usr_en).
//   It keeps that strobe up until sd_busy is sampled high.
//   Completion is the falling edge of sd_busy.
interface sdram_port_arbiter_if #(
    parameter int HADDR_WIDTH = 22
);
    logic                   dsp_req;
    logic [HADDR_WIDTH-1:0] dsp_addr;
    logic                   dsp_ack;
    logic                   dsp_valid;
    logic [15:0]            dsp_data;

    logic                   host_req;
    logic                   host_we;
    logic [HADDR_WIDTH-1:0] host_addr;
    logic [15:0]            host_wdata;
    logic                   host_ack;
    logic [15:0]            host_rdata;

    logic [HADDR_WIDTH-1:0] sd_wr_addr;
    logic [HADDR_WIDTH-1:0] sd_rd_addr;
    logic [15:0]            sd_wr_data;
    logic                   sd_wr_enable;
    logic                   sd_rd_enable;
    logic                   sd_rd_usr_en;
    logic                   sd_rd_type;
    logic                   sd_rd_type_clr;
    logic                   sd_rd_ready;
    logic [15:0]            sd_rd_data;
    logic [15:0]            sd_rd_data_bypass;
    logic                   sd_busy;

    // Arbiter view
    modport slave (
        input  dsp_req, dsp_addr, host_req, host_we, host_addr, host_wdata,
        input  sd_rd_type_clr, sd_rd_data, sd_rd_data_bypass, sd_busy,
        output dsp_ack, dsp_valid, dsp_data, host_ack, host_rdata,
        output sd_wr_addr, sd_rd_addr, sd_wr_data, sd_wr_enable, sd_rd_enable,
        output sd_rd_usr_en, sd_rd_type, sd_rd_ready
    );

    // Requesters plus controller view
    modport master (
        output dsp_req, dsp_addr, host_req, host_we, host_addr, host_wdata,
        output sd_rd_type_clr, sd_rd_data, sd_rd_data_bypass, sd_busy,
        input  dsp_ack, dsp_valid, dsp_data, host_ack, host_rdata,
        input  sd_wr_addr, sd_rd_addr, sd_wr_data, sd_wr_enable, sd_rd_enable,
        input  sd_rd_usr_en, sd_rd_type, sd_rd_ready
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one sdram_controller between the display burst fetch and the host port.
// It runs one controller transaction at a time.
// Macro SDRAM_ARB_RR_EN selects round-robin arbitration.
// When the macro is undefined, display has strict priority over host.
// dbg_state exposes the FSM state: 0 IDLE, 1 ISSUE, 2 WAIT_DONE, 3 DRAIN, 4 ACK.
module sdram_port_arbiter #(
    parameter int HADDR_WIDTH = 22,
    parameter int BURST_LEN   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sdram_port_arbiter_if.slave   bus,
    output logic [2:0]            dbg_state
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_DONE = 3'd2,
        DRAIN     = 3'd3,
        ACK       = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic                   own_dsp_q, own_dsp_d;
    logic                   is_wr_q, is_wr_d;
    logic [1:0]             beat_q, beat_d;
    logic                   wr_en_q, wr_en_d, rd_en_q, rd_en_d, usr_en_q, usr_en_d;
    logic                   rd_type_q, rd_type_d;
    logic [HADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [15:0]            wr_data_q, wr_data_d;
    logic                   dsp_ack_q, dsp_ack_d, dsp_valid_q, dsp_valid_d;
    logic                   rd_ready_q, rd_ready_d;
    logic                   host_ack_q, host_ack_d;
    logic [15:0]            host_rdata_q, host_rdata_d;
    logic                   grant_dsp;

`ifdef SDRAM_ARB_RR_EN
    logic                   last_host_q, last_host_d;
    // When both ports request, the port that did not win last time gets the grant.
    assign grant_dsp = bus.dsp_req && (!bus.host_req || last_host_q);
`else
    // Display always wins. Host is served only when display is not requesting.
    assign grant_dsp = bus.dsp_req;
`endif

    // State and registered outputs. Reset abandons any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            own_dsp_q    <= 1'b0;
            is_wr_q      <= 1'b0;
            beat_q       <= 2'd0;
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            usr_en_q     <= 1'b0;
            rd_type_q    <= 1'b0;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            wr_data_q    <= 16'h0;
            dsp_ack_q    <= 1'b0;
            dsp_valid_q  <= 1'b0;
            rd_ready_q   <= 1'b0;
            host_ack_q   <= 1'b0;
            host_rdata_q <= 16'h0;
`ifdef SDRAM_ARB_RR_EN
            last_host_q  <= 1'b1;  // first contested grant goes to display
`endif
        end else begin
            state_q      <= state_d;
            own_dsp_q    <= own_dsp_d;
            is_wr_q      <= is_wr_d;
            beat_q       <= beat_d;
            wr_en_q      <= wr_en_d;
            rd_en_q      <= rd_en_d;
            usr_en_q     <= usr_en_d;
            rd_type_q    <= rd_type_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            wr_data_q    <= wr_data_d;
            dsp_ack_q    <= dsp_ack_d;
            dsp_valid_q  <= dsp_valid_d;
            rd_ready_q   <= rd_ready_d;
            host_ack_q   <= host_ack_d;
            host_rdata_q <= host_rdata_d;
`ifdef SDRAM_ARB_RR_EN
            last_host_q  <= last_host_d;
`endif
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_d      = state_q;
        own_dsp_d    = own_dsp_q;
        is_wr_d      = is_wr_q;
        beat_d       = beat_q;
        wr_en_d      = wr_en_q;
        rd_en_d      = rd_en_q;
        usr_en_d     = usr_en_q;
        rd_type_d    = rd_type_q;
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        wr_data_d    = wr_data_q;
        dsp_ack_d    = 1'b0;
        dsp_valid_d  = 1'b0;
        rd_ready_d   = 1'b0;
        host_ack_d   = 1'b0;
        host_rdata_d = host_rdata_q;
`ifdef SDRAM_ARB_RR_EN
        last_host_d  = last_host_q;
`endif
        case (state_q)
            IDLE: begin
                // Never start while the controller is busy, including its init period.
                if (!bus.sd_busy && (bus.dsp_req || bus.host_req)) begin
                    state_d   = ISSUE;
                    own_dsp_d = grant_dsp;
`ifdef SDRAM_ARB_RR_EN
                    last_host_d = !grant_dsp;
`endif
                    if (grant_dsp) begin
                        // Bursts are aligned to BURST_LEN words.
                        rd_addr_d = bus.dsp_addr & ~(HADDR_WIDTH'(3));
                        rd_en_d   = 1'b1;
                    end else begin
                        is_wr_d   = bus.host_we;
                        wr_addr_d = bus.host_addr;
                        if (bus.host_we) begin
                            wr_data_d = bus.host_wdata;
                            wr_en_d   = 1'b1;
                        end else begin
                            usr_en_d  = 1'b1;
                            rd_type_d = 1'b1;
                        end
                    end
                end
            end
            ISSUE: begin
                // The strobe is held while the controller is refreshing.
                // It drops once the controller accepts the request.
                if (bus.sd_busy) begin
                    wr_en_d   = 1'b0;
                    rd_en_d   = 1'b0;
                    usr_en_d  = 1'b0;
                    dsp_ack_d = own_dsp_q;
                    state_d   = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!bus.sd_busy) begin
                    if (own_dsp_q) begin
                        state_d     = DRAIN;
                        beat_d      = 2'd0;
                        dsp_valid_d = 1'b1;
                        rd_ready_d  = 1'b1;
                    end else begin
                        state_d    = ACK;
                        host_ack_d = 1'b1;
                        if (!is_wr_q) host_rdata_d = bus.sd_rd_data_bypass;
                    end
                end
            end
            DRAIN: begin
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'(BURST_LEN - 1)) begin
                    state_d = IDLE;
                end else begin
                    dsp_valid_d = 1'b1;
                    rd_ready_d  = 1'b1;
                end
            end
            ACK: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // The controller clear wins over a same-cycle set.
        if (bus.sd_rd_type_clr) rd_type_d = 1'b0;
    end

    assign bus.sd_wr_enable = wr_en_q;
    assign bus.sd_rd_enable = rd_en_q;
    assign bus.sd_rd_usr_en = usr_en_q;
    assign bus.sd_rd_type   = rd_type_q;
    assign bus.sd_wr_addr   = wr_addr_q;
    assign bus.sd_rd_addr   = rd_addr_q;
    assign bus.sd_wr_data   = wr_data_q;
    assign bus.dsp_ack      = dsp_ack_q;
    assign bus.dsp_valid    = dsp_valid_q;
    assign bus.sd_rd_ready  = rd_ready_q;
    assign bus.host_ack     = host_ack_q;
    assign bus.host_rdata   = host_rdata_q;
    // The controller's burst register head is already registered.
    // It advances on each sd_rd_ready cycle, so it is forwarded during valid beats.
    // The output is zero otherwise.
    assign bus.dsp_data     = dsp_valid_q ? bus.sd_rd_data : 16'h0;
    assign dbg_state        = state_q;
endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Two-port scheduler in front of `sdram_controller`, sharing the single SDRAM between the TFT frame-buffer fetch (4-word burst reads) and a host port (single-word writes and bypass reads). It issues one controller transaction at a time, holds each request strobe until the controller accepts it (busy rises), waits for completion (busy falls), then returns read data to the owning requester.

## Interface
- `HADDR_WIDTH`, default 22, linear SDRAM word address width {bank,row,col}.
- `BURST_LEN`, default 4, display burst length in words; fixed, matches controller mode register.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `dsp_req`  in  1  display burst request level; held until `dsp_ack`.
- `dsp_addr`  in  HADDR_WIDTH  burst start address; bits [1:0] forced to 0.
- `dsp_ack`  out  1  one-cycle pulse, burst accepted by controller.
- `dsp_valid`  out  1  one beat of burst data on `dsp_data`.
- `dsp_data`  out  16  burst read word.
- `host_req`  in  1  host request level; held until `host_ack`.
- `host_we`  in  1  1 = write, 0 = read; sampled with `host_req` at grant.
- `host_addr`  in  HADDR_WIDTH  host word address.
- `host_wdata`  in  16  host write data.
- `host_ack`  out  1  one-cycle pulse, host transaction complete.
- `host_rdata`  out  16  host read data, valid with `host_ack` on reads.
- `sd_wr_addr`, `sd_rd_addr`  out  HADDR_WIDTH  controller address buses.
- `sd_wr_data`  out  16  controller write data.
- `sd_wr_enable`, `sd_rd_enable`, `sd_rd_usr_en`  out  1  controller request strobes.
- `sd_rd_type`  out  1  1 = bypass single read.
- `sd_rd_type_clr`  in  1  controller clear for `sd_rd_type`.
- `sd_rd_ready`  out  1  shift controller burst register.
- `sd_rd_data`, `sd_rd_data_bypass`  in  16  burst / bypass read data.
- `sd_busy`  in  1  controller busy (1 out of reset until init completes).

## Operation
- FSM states: IDLE, ISSUE, WAIT_DONE, DRAIN, ACK.
- IDLE: arbitrate only when `sd_busy`=0. Display wins over host (strict priority) unless `SDRAM_ARB_RR_EN`. Winner's address/data/type latched into registers.
- ISSUE: drive exactly one strobe: display -> `sd_rd_enable` with `sd_rd_addr`; host write -> `sd_wr_enable` with `sd_wr_addr`/`sd_wr_data`; host read -> `sd_rd_usr_en` with `sd_wr_addr` and `sd_rd_type`=1. Strobe held (controller may be in refresh, busy stays 0) until `sd_busy`=1; then strobe drops, `dsp_ack` pulses for display, go WAIT_DONE.
- WAIT_DONE: wait `sd_busy`=0. Display -> DRAIN; host -> ACK.
- DRAIN: BURST_LEN cycles: `dsp_valid`=1, `dsp_data`=`sd_rd_data`, `sd_rd_ready`=1; 2-bit beat counter; words in ascending column order; last beat -> IDLE.
- ACK: `host_ack`=1 one cycle; on read `host_rdata`=`sd_rd_data_bypass` (registered); -> IDLE.
- `sd_rd_type` set on host-read grant, cleared when `sd_rd_type_clr`=1 (clear wins if simultaneous with set, which cannot occur legally).
- Requester dropping `*_req` after grant: transaction still completes, ack still issued.
- Reset mid-transaction: all state, strobes and outputs to reset values immediately; the in-flight controller op is abandoned (controller shares the same reset).

## Timing
- All outputs registered. Reset values: all strobes, `dsp_ack`, `dsp_valid`, `host_ack`, `sd_rd_ready`, `sd_rd_type` = 0; data/address outputs = 0; FSM = IDLE.
- Request seen in IDLE at cycle N -> strobe high at N+1.
- `dsp_ack` one cycle after `sd_busy` first samples 1.
- First `dsp_valid` one cycle after `sd_busy` samples 0 in WAIT_DONE; 4 consecutive beats, no gaps.
- Next arbitration no earlier than one cycle after DRAIN/ACK exit.
- No new request issued while `sd_busy`=1, including post-reset controller init.

## Configuration
- `SDRAM_ARB_RR_EN` defined: round-robin; 1-bit last-grant pointer, when both requests pending the port not granted last wins; pointer updates on each grant.
- Undefined: display strict priority; host served only when `dsp_req`=0 in IDLE.

## Test plan
- Reset, hold `sd_busy`=1 for 40 cycles, assert `host_req` -> no strobe until `sd_busy`=0, then `sd_wr_enable` next cycle.
- Host write addr 0x00123, data 0xA5A5 -> `sd_wr_addr`=0x00123, `sd_wr_data`=0xA5A5, strobe held until busy rises, one `host_ack`.
- Display burst addr 0x00402 -> `sd_rd_addr`=0x00400, `dsp_ack` once, 4 `dsp_valid` beats 0x1111/0x2222/0x3333/0x4444 from controller model, 4 `sd_rd_ready` pulses.
- Host read with controller model returning bypass 0xBEEF -> `sd_rd_usr_en`, `sd_rd_type`=1 until `sd_rd_type_clr`, `host_ack` with `host_rdata`=0xBEEF.
- Both requests pending continuously, 6 grants -> without macro all display; with `SDRAM_ARB_RR_EN` alternating D,H,D,H,D,H.
- Controller refresh delays busy by 12 cycles -> strobe held 12+ cycles, exactly one transaction issued; `rst_n` low during DRAIN -> `dsp_valid`=0 next cycle, FSM IDLE.
